// File: rtl/packet_buffer_reader.sv
// Read-side controller for the dual-port packet buffer.
// It accepts (address, length) descriptors and streams the words out through a 2-entry skid FIFO.
module packet_buffer_reader #(
  parameter int MEM_SIZE   = 1024,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8,
  localparam int AW        = $clog2(MEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [AW-1:0]         desc_addr,
  input  logic [LEN_WIDTH-1:0]  desc_len,
  output logic [AW-1:0]         mem_addr,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_first,
  output logic                  out_last
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         ptr_q;
  logic [AW-1:0]         last_addr_q;
  logic [LEN_WIDTH-1:0]  rem_issue_q;
  logic [LEN_WIDTH-1:0]  rem_out_q;
  logic                  first_q;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic                  head_q;
  logic [1:0]            count_q;

  logic accept;
  logic xfer;
  logic issue;
  logic wr_idx;

  assign desc_ready = (state_q == IDLE) && !reset;
  assign accept     = desc_valid && desc_ready;
  assign out_valid  = (count_q != 2'd0);
  assign xfer       = out_valid && out_ready;
  // A transfer this cycle frees a slot, so a full FIFO may still issue.
  assign issue      = !reset && (state_q == READ) &&
                      (((count_q + {1'b0, inflight_q}) < 2'd2) || xfer);
  assign mem_re     = issue;
  assign mem_addr   = issue ? ptr_q : last_addr_q;
  assign wr_idx     = head_q ^ count_q[0];

  assign out_data   = fifo_q[head_q];
  assign out_first  = out_valid && first_q;
  assign out_last   = out_valid && (rem_out_q == LEN_WIDTH'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && (desc_len != '0)) state_d = READ;
      READ:    if (issue && (rem_issue_q == LEN_WIDTH'(1))) state_d = DRAIN;
      DRAIN:   if (xfer && (rem_out_q == LEN_WIDTH'(1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      last_addr_q <= '0;
      rem_issue_q <= '0;
      rem_out_q   <= '0;
      first_q     <= 1'b0;
      inflight_q  <= 1'b0;
      head_q      <= 1'b0;
      count_q     <= 2'd0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (issue) begin
        ptr_q       <= ptr_q + AW'(1);
        last_addr_q <= ptr_q;
        rem_issue_q <= rem_issue_q - LEN_WIDTH'(1);
      end
      if (xfer) begin
        rem_out_q <= rem_out_q - LEN_WIDTH'(1);
        first_q   <= 1'b0;
        head_q    <= ~head_q;
      end
      if (accept && (desc_len != '0)) begin
        ptr_q       <= desc_addr;
        rem_issue_q <= desc_len;
        rem_out_q   <= desc_len;
        first_q     <= 1'b1;
      end
      // Read data lands one cycle after its mem_re.
      if (inflight_q) fifo_q[wr_idx] <= mem_q;
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, xfer};
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(inflight_q && !xfer && (count_q == 2'd2)));

endmodule
